// File: rtl/pq_stream_ctrl.sv
// pq_stream_ctrl: valid/ready stream front end for the min-priority queue.
// Registered one-entry output slot, occupancy count and flush sequencing.
package pq_pkg;
  localparam int KEY_W = 8;
  localparam int VAL_W = 8;
  localparam int PQ_CAPACITY = 8;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  localparam logic [KEY_W-1:0] KEYINF = '1;
  localparam logic [VAL_W-1:0] VAL0 = '0;
endpackage

module pq_stream_ctrl
  import pq_pkg::*;
#(
  parameter int PQ_CAP = PQ_CAPACITY,
  parameter int CNT_W = $clog2(PQ_CAP + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  kv_t              s_kv,
  output logic             m_valid,
  input  logic             m_ready,
  output kv_t              m_kv,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             err_key,
  output logic             pq_enq,
  output logic             pq_deq,
  output kv_t              pq_kvi,
  input  kv_t              pq_kvo,
  input  logic             pq_full,
  input  logic             pq_empty,
  input  logic             pq_busy
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam kv_t KV_NULL = '{key: KEYINF, val: VAL0};

  state_t state;
  state_t nstate;
  logic   key_inf;
  logic   s_fire;
  logic   m_fire;

  assign pq_kvi  = s_kv;
  assign key_inf = (s_kv.key == KEYINF);
  assign s_fire  = s_valid && s_ready;
  assign m_fire  = m_valid && m_ready;

  always_comb begin
    nstate  = state;
    s_ready = 1'b0;
    pq_enq  = 1'b0;
    pq_deq  = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          s_ready = !pq_full && !pq_busy;
          pq_enq  = s_valid && !pq_full && !pq_busy && !key_inf;
          pq_deq  = !pq_empty && !pq_busy && (!m_valid || m_ready);
          if (flush) nstate = FLUSH;
        end
        FLUSH: begin
          pq_deq = !pq_empty && !pq_busy;
          if (pq_empty) nstate = RUN;
        end
        default: nstate = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      m_valid <= 1'b0;
      m_kv    <= KV_NULL;
      count   <= '0;
      err_key <= 1'b0;
    end else begin
      state <= nstate;
      if (s_fire && key_inf) err_key <= 1'b1;
      if (state == RUN) begin
        count <= count + CNT_W'(pq_enq) - CNT_W'(m_fire);
        // Entering FLUSH drops the slot even if a deq refilled it.
        if (nstate == FLUSH) begin
          m_valid <= 1'b0;
          m_kv    <= KV_NULL;
        end else if (pq_deq) begin
          m_valid <= 1'b1;
          m_kv    <= pq_kvo;
        end else if (m_fire) begin
          m_valid <= 1'b0;
          m_kv    <= KV_NULL;
        end
      end else begin
        m_valid <= 1'b0;
        m_kv    <= KV_NULL;
        if (pq_empty) count <= '0;
      end
    end
  end

endmodule
